// File: rtl/fx_mul_pipe.sv
// Signed fixed-point pipelined multiplier: abs/sign split, shift-and-add partial products,
// registered pairwise adder tree, round, then saturate and re-apply the sign. Global stall on backpressure.
module fx_mul_pipe #(
    parameter int W     = 32,
    parameter int FRAC  = 16,
    parameter int RND   = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_p,
    output logic             out_sat,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int D      = $clog2(W);
    localparam int STAGES = D + 4;   // S0, S1, T1..TD, R, O
    localparam int SB     = STAGES - 1;
    localparam int PW     = 2 * W;

    function automatic int lvl_cnt(input int l);
        int n;
        n = W;
        for (int k = 0; k < l; k++) n = (n + 1) / 2;
        return n;
    endfunction

    function automatic int lvl_off(input int l);
        int o;
        o = 0;
        for (int k = 0; k < l; k++) o += lvl_cnt(k);
        return o;
    endfunction

    localparam int TOT = lvl_off(D + 1);
    localparam logic [PW-1:0] RNDC    = (RND != 0) ? ({{(PW-1){1'b0}}, 1'b1} << (FRAC - 1)) : '0;
    localparam logic [PW-1:0] POS_LIM = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [PW-1:0] NEG_LIM = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

    logic                       en;
    logic [STAGES-1:0]          vld_q;
    logic [SB-1:0]              sgn_q;
    logic [SB-1:0][TAG_W-1:0]   tag_q;
    logic [W-1:0]               abs_a_q, abs_b_q;
    logic [TOT-1:0][PW-1:0]     tree_q;
    logic [PW-1:0]              mag_q;
    logic [W-1:0]               out_p_q, out_p_d;
    logic                       out_sat_q, out_sat_d;
    logic [TAG_W-1:0]           out_tag_q;

    assign en        = !out_valid | out_ready;
    assign in_ready  = en;
    assign out_valid = vld_q[STAGES-1];
    assign busy      = |vld_q;
    assign out_p     = out_p_q;
    assign out_sat   = out_sat_q;
    assign out_tag   = out_tag_q;

    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else if (en) vld_q <= {vld_q[STAGES-2:0], in_valid};
    end

    // Sign and tag ride alongside the datapath up to the rounding stage.
    always_ff @(posedge clk) begin
        if (en) begin
            sgn_q   <= {sgn_q[SB-2:0], in_a[W-1] ^ in_b[W-1]};
            tag_q   <= {tag_q[SB-2:0], in_tag};
            abs_a_q <= in_a[W-1] ? -in_a : in_a;
            abs_b_q <= in_b[W-1] ? -in_b : in_b;
        end
    end

    // Level 0 holds the W partial products; each later level halves the node count, odd node passes through.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < W; i++)
                tree_q[i] <= abs_b_q[i] ? (PW'(abs_a_q) << i) : '0;
            for (int l = 1; l <= D; l++) begin
                for (int j = 0; j < lvl_cnt(l); j++) begin
                    if (2*j + 1 < lvl_cnt(l-1))
                        tree_q[lvl_off(l)+j] <= tree_q[lvl_off(l-1)+2*j] + tree_q[lvl_off(l-1)+2*j+1];
                    else
                        tree_q[lvl_off(l)+j] <= tree_q[lvl_off(l-1)+2*j];
                end
            end
            mag_q <= (tree_q[TOT-1] + RNDC) >> FRAC;
        end
    end

    always_comb begin
        out_p_d   = sgn_q[SB-1] ? -mag_q[W-1:0] : mag_q[W-1:0];
        out_sat_d = 1'b0;
        if (!sgn_q[SB-1] && mag_q > POS_LIM) begin
            out_p_d   = {1'b0, {(W-1){1'b1}}};
            out_sat_d = 1'b1;
        end else if (sgn_q[SB-1] && mag_q > NEG_LIM) begin
            out_p_d   = {1'b1, {(W-1){1'b0}}};
            out_sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_p_q   <= '0;
            out_sat_q <= 1'b0;
            out_tag_q <= '0;
        end else if (en) begin
            out_p_q   <= out_p_d;
            out_sat_q <= out_sat_d;
            out_tag_q <= tag_q[SB-1];
        end
    end

endmodule

// File: tb/tb_fx_mul_pipe.sv
// Scoreboard bench: main W=32 instance with backpressure and reset, plus RND=0, W=16 and W=24 instances.
module tb_fx_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_sat, busy;
    logic [31:0] in_a = '0, in_b = '0, out_p;
    logic [3:0]  in_tag = '0, out_tag;
    bit          lat_flag = 1'b0, bp = 1'b0;

    logic        x_valid = 1'b0;
    logic [31:0] r0_a = '0, r0_b = '0, r0_p;
    logic [15:0] h_a = '0, h_b = '0, h_p;
    logic [23:0] t_a = '0, t_b = '0, t_p;
    logic        r0_rdy, r0_ov, r0_s, r0_busy, h_rdy, h_ov, h_s, h_busy, t_rdy, t_ov, t_s, t_busy;
    logic [3:0]  r0_tag, h_tag, t_tag;

    fx_mul_pipe #(.W(32), .FRAC(16), .RND(1), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .out_sat(out_sat), .out_tag(out_tag), .busy(busy));
    fx_mul_pipe #(.W(32), .FRAC(16), .RND(0), .TAG_W(4)) u_r0 (
        .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(r0_rdy), .in_a(r0_a), .in_b(r0_b),
        .in_tag(4'd0), .out_valid(r0_ov), .out_ready(1'b1), .out_p(r0_p),
        .out_sat(r0_s), .out_tag(r0_tag), .busy(r0_busy));
    fx_mul_pipe #(.W(16), .FRAC(8), .RND(1), .TAG_W(4)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(h_rdy), .in_a(h_a), .in_b(h_b),
        .in_tag(4'd0), .out_valid(h_ov), .out_ready(1'b1), .out_p(h_p),
        .out_sat(h_s), .out_tag(h_tag), .busy(h_busy));
    fx_mul_pipe #(.W(24), .FRAC(12), .RND(1), .TAG_W(4)) u_w24 (
        .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(t_rdy), .in_a(t_a), .in_b(t_b),
        .in_tag(4'd0), .out_valid(t_ov), .out_ready(1'b1), .out_p(t_p),
        .out_sat(t_s), .out_tag(t_tag), .busy(t_busy));

    int n_tests = 0, n_fail = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: sign-magnitude product with a plain wide multiply, round, shift, clip.
    function automatic logic [64:0] ref_mul(input int w, input int frac, input bit rnd,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] am, bm, m, lim;
        logic [63:0]  msk, p;
        bit           s, sat;
        msk = (64'd1 << w) - 64'd1;
        am  = {64'b0, a & msk};
        bm  = {64'b0, b & msk};
        s   = a[w-1] ^ b[w-1];
        if (a[w-1]) am = (128'd1 << w) - am;
        if (b[w-1]) bm = (128'd1 << w) - bm;
        m = am * bm;
        if (rnd) m = m + (128'd1 << (frac - 1));
        m   = m >> frac;
        lim = 128'd1 << (w - 1);
        sat = 1'b0;
        if (!s && m > lim - 128'd1) begin
            sat = 1'b1; p = lim[63:0] - 64'd1;
        end else if (s && m > lim) begin
            sat = 1'b1; p = lim[63:0];
        end else begin
            p = s ? -m[63:0] : m[63:0];
        end
        return {sat, p & msk};
    endfunction

    function automatic logic [63:0] gen(input int w);
        logic [63:0] msk;
        msk = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0:       return (64'd1 << (w - 1)) - 64'd1;
            1:       return 64'd1 << (w - 1);
            2:       return (64'd1 << (w - 1)) + 64'd1;
            3:       return msk & ~({32'b0, $urandom()} & ((64'd1 << (w / 2)) - 64'd1));
            4:       return {32'b0, $urandom()} & ((64'd1 << (w / 2 + 2)) - 64'd1);
            default: return {$urandom(), $urandom()} & msk;
        endcase
    endfunction

    typedef struct { logic [31:0] p; logic sat; logic [3:0] tag; int unsigned cyc; bit lat; } exp_t;
    typedef struct { logic [63:0] p; logic sat; } aexp_t;
    exp_t  exp_q[$];
    aexp_t q0[$], q16[$], q24[$];

    always @(negedge clk) begin
        exp_t        e;
        logic [64:0] r;
        if (rst) begin
            exp_q.delete();
        end else begin
            chk("in_ready", in_ready, !out_valid | out_ready);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("stale result", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("p", out_p, e.p);
                    chk("sat", out_sat, e.sat);
                    chk("tag", out_tag, e.tag);
                    if (e.lat) chk("latency", cyc - e.cyc, 9);
                end
            end
            if (in_valid && in_ready) begin
                r = ref_mul(32, 16, 1'b1, {32'b0, in_a}, {32'b0, in_b});
                e.p = r[31:0]; e.sat = r[64]; e.tag = in_tag; e.cyc = cyc; e.lat = lat_flag;
                exp_q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        aexp_t       e;
        logic [64:0] r;
        if (rst) begin
            q0.delete(); q16.delete(); q24.delete();
        end else begin
            if (r0_ov) begin
                if (q0.size() == 0) chk("r0 stale", 1, 0);
                else begin e = q0.pop_front(); chk("r0 p", {32'b0, r0_p}, e.p); chk("r0 sat", r0_s, e.sat); end
            end
            if (h_ov) begin
                if (q16.size() == 0) chk("w16 stale", 1, 0);
                else begin e = q16.pop_front(); chk("w16 p", {48'b0, h_p}, e.p); chk("w16 sat", h_s, e.sat); end
            end
            if (t_ov) begin
                if (q24.size() == 0) chk("w24 stale", 1, 0);
                else begin e = q24.pop_front(); chk("w24 p", {40'b0, t_p}, e.p); chk("w24 sat", t_s, e.sat); end
            end
            if (x_valid) begin
                r = ref_mul(32, 16, 1'b0, {32'b0, r0_a}, {32'b0, r0_b}); e.p = r[63:0]; e.sat = r[64]; q0.push_back(e);
                r = ref_mul(16, 8, 1'b1, {48'b0, h_a}, {48'b0, h_b});    e.p = r[63:0]; e.sat = r[64]; q16.push_back(e);
                r = ref_mul(24, 12, 1'b1, {40'b0, t_a}, {40'b0, t_b});   e.p = r[63:0]; e.sat = r[64]; q24.push_back(e);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t, input bit lat);
        int n;
        bit acc;
        n = 0;
        in_a = a; in_b = b; in_tag = t; lat_flag = lat; in_valid = 1'b1;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
        end while (!acc && n < 100);
        if (!acc) chk("send timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", (exp_q.size() == 0 && !busy), 1);
    endtask

    initial begin
        logic [31:0] a, b;
        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst out_p", out_p, 0);
        chk("rst out_sat", out_sat, 0);
        chk("rst out_tag", out_tag, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst in_ready", in_ready, 1);

        // directed: basic, sign, rounding, saturation; latency checked on each
        send(32'h0001_8000, 32'h0002_0000, 4'd1, 1'b1);
        send(32'hFFFE_8000, 32'h0002_0000, 4'd2, 1'b1);
        send(32'h0000_0001, 32'h0000_8000, 4'd3, 1'b1);
        send(32'hFFFF_FFFF, 32'h0000_8000, 4'd4, 1'b1);
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd5, 1'b1);
        send(32'h8000_0000, 32'h0001_0000, 4'd6, 1'b1);
        send(32'h8000_0000, 32'hFFFF_0000, 4'd7, 1'b1);
        drain();

        // streaming under random backpressure
        bp = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = $urandom(); b = $urandom();
            if (i % 3 != 0) begin a = {{12{a[19]}}, a[19:0]}; b = {{12{b[19]}}, b[19:0]}; end
            send(a, b, 4'(i % 16), 1'b0);
        end
        bp = 1'b0;
        drain();

        // reset with six pairs in flight
        for (int i = 0; i < 6; i++) send($urandom(), 32'h0001_0000, 4'(i), 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst busy", busy, 0);
        send(32'h0003_0000, 32'hFFFF_8000, 4'd9, 1'b1);
        drain();

        // RND=0 and width sweep instances
        for (int i = 0; i < 40; i++) begin
            x_valid = 1'b1;
            if (i == 0)      begin r0_a = 32'h0000_0001; r0_b = 32'h0000_8000; end
            else if (i == 1) begin r0_a = 32'hFFFF_FFFF; r0_b = 32'h0000_8000; end
            else             begin r0_a = 32'(gen(32)); r0_b = 32'(gen(32)); end
            h_a = 16'(gen(16)); h_b = 16'(gen(16));
            t_a = 24'(gen(24)); t_b = 24'(gen(24));
            @(posedge clk); #1;
        end
        x_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("sweep drained", (q0.size() == 0 && q16.size() == 0 && q24.size() == 0), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
